// File: rtl/valid_fire_ctrl.sv
// valid_fire_ctrl: per-PE firing controller.
// Gathers operand-valid tokens, compares them against the configured required
// mask and holds fire until the datapath acknowledges. The ack clears the
// consumed tokens and re-arms the controller.
// Optional feature: define VALID_FIRE_TIMEOUT_EN to enable the fire-without-ack
// watchdog. Without it, timeout_err is tied to 0.
module valid_fire_ctrl #(
  parameter int DATA_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_valid_bits,
  input  logic                 cfg_exclude_lsb,
  output logic                 cfg_rej,
  input  logic [DATA_SIZE-1:0] tok_set,
  output logic [DATA_SIZE-1:0] tok_q,
  output logic                 tok_ovf,
  output logic                 fire,
  input  logic                 fire_ack,
  output logic [DATA_SIZE-1:0] consumed_mask,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FIRE
  } state_t;

  state_t               state;
  state_t               stateNext;
  logic [2:0]           validBits;
  logic                 excludeLsb;
  logic [DATA_SIZE-1:0] effMask;
  logic [DATA_SIZE-1:0] newEffMask;
  logic [DATA_SIZE-1:0] clrMask;
  logic                 allOn;
  logic                 cfgAccept;
  logic                 ackFire;

  // Required-token mask: the low vb bits, saturating at the full width,
  // with bit 0 dropped when the LSB operand is not needed.
  function automatic logic [DATA_SIZE-1:0] calcMask(input logic [2:0] vb, input logic excl);
    logic [DATA_SIZE-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_SIZE; i++) begin
      if (i < int'(vb)) m[i] = 1'b1;
    end
    if (excl) m[0] = 1'b0;
    return m;
  endfunction

  assign effMask    = calcMask(validBits, excludeLsb);
  assign newEffMask = calcMask(cfg_valid_bits, cfg_exclude_lsb);
  assign allOn      = ((tok_q & effMask) == effMask) && (effMask != '0);
  assign cfgAccept  = cfg_we && (state != FIRE);
  assign ackFire    = fire_ack && (state == FIRE);
  assign clrMask    = ackFire ? effMask : '0;
  assign busy       = (state != IDLE);

  // Next-state decode; a config write in WAIT takes priority over firing so
  // that the new mask is the one checked from the following cycle.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (cfgAccept && (newEffMask != '0)) stateNext = WAIT;
      end
      WAIT: begin
        if (cfgAccept) begin
          if (newEffMask == '0) stateNext = IDLE;
        end else if (allOn) begin
          stateNext = FIRE;
        end
      end
      FIRE: begin
        if (fire_ack) stateNext = WAIT;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, config, token register and the registered pulse/level outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      validBits     <= '0;
      excludeLsb    <= 1'b0;
      tok_q         <= '0;
      tok_ovf       <= 1'b0;
      consumed_mask <= '0;
      cfg_rej       <= 1'b0;
      fire          <= 1'b0;
    end else begin
      state <= stateNext;
      if (cfgAccept) begin
        validBits  <= cfg_valid_bits;
        excludeLsb <= cfg_exclude_lsb;
      end
      tok_q         <= (tok_q & ~clrMask) | tok_set;
      tok_ovf       <= |(tok_set & tok_q & ~clrMask);
      consumed_mask <= clrMask;
      cfg_rej       <= cfg_we && (state == FIRE);
      fire          <= (stateNext == FIRE);
    end
  end

`ifdef VALID_FIRE_TIMEOUT_EN
  localparam int CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] fireCnt;
  logic            timeoutErr;

  // Watchdog: count cycles spent in FIRE, latch the error on reaching the
  // limit, and only clear it through an accepted config write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fireCnt    <= '0;
      timeoutErr <= 1'b0;
    end else if (state == FIRE) begin
      if (fireCnt != CntW'(TIMEOUT_CYCLES)) fireCnt <= fireCnt + CntW'(1);
      if (fireCnt == CntW'(TIMEOUT_CYCLES - 1)) timeoutErr <= 1'b1;
    end else begin
      fireCnt <= '0;
      if (cfgAccept) timeoutErr <= 1'b0;
    end
  end

  assign timeout_err = timeoutErr;
`else
  localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;

  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_valid_fire_ctrl.sv
// tb_valid_fire_ctrl: directed vector table, hand-written corner sequences
// (async reset mid-fire, watchdog when VALID_FIRE_TIMEOUT_EN is defined) and
// randomized traffic against a behavioural model of the firing rules.
module tb_valid_fire_ctrl;

`ifdef VALID_FIRE_TIMEOUT_EN
  localparam int TimeoutLimit = 4;
`else
  localparam int TimeoutLimit = 255;
`endif

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_valid_bits;
  logic       cfg_exclude_lsb;
  logic       cfg_rej;
  logic [7:0] tok_set;
  logic [7:0] tok_q;
  logic       tok_ovf;
  logic       fire;
  logic       fire_ack;
  logic [7:0] consumed_mask;
  logic       busy;
  logic       timeout_err;

  int checkCount = 0;
  int failCount  = 0;

  valid_fire_ctrl #(
    .DATA_SIZE(8),
    .TIMEOUT_CYCLES(TimeoutLimit)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_valid_bits(cfg_valid_bits),
    .cfg_exclude_lsb(cfg_exclude_lsb),
    .cfg_rej(cfg_rej),
    .tok_set(tok_set),
    .tok_q(tok_q),
    .tok_ovf(tok_ovf),
    .fire(fire),
    .fire_ack(fire_ack),
    .consumed_mask(consumed_mask),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  typedef struct {
    logic       we;
    logic [2:0] vb;
    logic       ex;
    logic [7:0] tok;
    logic       ack;
    logic       expFire;
    logic [7:0] expTokQ;
    logic [7:0] expCons;
    logic       expOvf;
    logic       expRej;
    logic       expBusy;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  int  mVb;
  bit  mEx;
  int  mTok;
  bit  mFiring;
  int  mAge;
  bit  mErr;

  function automatic int maskOf(input int vb, input bit ex);
    int m;
    if (vb == 0) m = 0;
    else if (vb >= 8) m = 255;
    else m = (1 << vb) - 1;
    if (ex) m = m & 254;
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] vb, input logic ex,
                               input logic [7:0] tok, input logic ack);
    @(negedge clk);
    cfg_we          = we;
    cfg_valid_bits  = vb;
    cfg_exclude_lsb = ex;
    tok_set         = tok;
    fire_ack        = ack;
  endtask

  task automatic addVec(input logic we, input logic [2:0] vb, input logic ex, input logic [7:0] tok,
                        input logic ack, input logic eFire, input logic [7:0] eTok,
                        input logic [7:0] eCons, input logic eOvf, input logic eRej, input logic eBusy);
    vec_t v;
    v.we = we; v.vb = vb; v.ex = ex; v.tok = tok; v.ack = ack;
    v.expFire = eFire; v.expTokQ = eTok; v.expCons = eCons;
    v.expOvf = eOvf; v.expRej = eRej; v.expBusy = eBusy;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    @(negedge clk);
    cfg_we = 1'b0; cfg_valid_bits = '0; cfg_exclude_lsb = 1'b0; tok_set = '0; fire_ack = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mVb = 0; mEx = 0; mTok = 0; mFiring = 0; mAge = 0; mErr = 0;
  endtask

  // Model one clock edge from the specification's rules; the model's
  // "state" is only whether a firing is outstanding, idle-ness follows from
  // the configured mask being empty.
  task automatic modelStep(input bit we, input int vb, input bit ex, input int tok, input bit ack,
                           output int eCons, output bit eOvf, output bit eRej);
    int  eff;
    int  clr;
    bit  cfgOk;
    bit  ackOk;
    bit  wasFiring;
    eff       = maskOf(mVb, mEx);
    cfgOk     = we && !mFiring;
    ackOk     = ack && mFiring;
    clr       = ackOk ? eff : 0;
    eOvf      = ((tok & mTok & ~clr & 255) != 0);
    eRej      = we && mFiring;
    eCons     = clr;
    wasFiring = mFiring;
    if (mFiring) mFiring = !ack;
    else mFiring = !cfgOk && (eff != 0) && ((mTok & eff) == eff);
    if (wasFiring) begin
      mAge++;
      if (mAge == TimeoutLimit) mErr = 1;
    end else begin
      mAge = 0;
      if (cfgOk) mErr = 0;
    end
    mTok = ((mTok & ~clr) | tok) & 255;
    if (cfgOk) begin
      mVb = vb;
      mEx = ex;
    end
  endtask

  initial begin
    int  eCons;
    bit  eOvf;
    bit  eRej;
    bit  seen;
    bit  rWe;
    int  rVb;
    bit  rEx;
    int  rTok;
    bit  rAck;
    bit  expErr;

    rst_n = 1'b1;
    cfg_we = 1'b0; cfg_valid_bits = '0; cfg_exclude_lsb = 1'b0; tok_set = '0; fire_ack = 1'b0;
    doReset();

    // Reset state
    @(posedge clk); #1;
    checkOutput("reset_fire", fire, 0);
    checkOutput("reset_tok_q", tok_q, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_consumed", consumed_mask, 0);
    checkOutput("reset_ovf", tok_ovf, 0);
    checkOutput("reset_rej", cfg_rej, 0);
    checkOutput("reset_timeout", timeout_err, 0);

    //     we vb ex tok   ack  fire tokq  cons  ovf rej busy
    // basic fire, 3 bits
    addVec(1, 3, 0, 8'h00, 0,  0, 8'h00, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h07, 0,  0, 8'h07, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 0,  1, 8'h07, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 0,  1, 8'h07, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 1,  0, 8'h00, 8'h07, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 0,  0, 8'h00, 8'h00, 0, 0, 1);
    // exclude LSB
    addVec(1, 3, 1, 8'h00, 0,  0, 8'h00, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h06, 0,  0, 8'h06, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 0,  1, 8'h06, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 1,  0, 8'h00, 8'h06, 0, 0, 1);
    addVec(0, 0, 0, 8'h01, 0,  0, 8'h01, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 0,  0, 8'h01, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 0,  0, 8'h01, 8'h00, 0, 0, 1);
    // empty masks stay idle
    addVec(1, 0, 0, 8'h00, 0,  0, 8'h01, 8'h00, 0, 0, 0);
    addVec(0, 0, 0, 8'hFF, 0,  0, 8'hFF, 8'h00, 1, 0, 0);
    addVec(0, 0, 0, 8'h00, 0,  0, 8'hFF, 8'h00, 0, 0, 0);
    addVec(1, 1, 1, 8'h00, 0,  0, 8'hFF, 8'h00, 0, 0, 0);
    addVec(0, 0, 0, 8'hFF, 0,  0, 8'hFF, 8'h00, 1, 0, 0);
    addVec(0, 0, 0, 8'h00, 0,  0, 8'hFF, 8'h00, 0, 0, 0);
    // 7 bits, then set-wins-over-clear refire with 1 bit
    addVec(1, 7, 0, 8'h00, 0,  0, 8'hFF, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 0,  1, 8'hFF, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 1,  0, 8'h80, 8'h7F, 0, 0, 1);
    addVec(1, 1, 0, 8'h00, 0,  0, 8'h80, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h01, 0,  0, 8'h81, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 0,  1, 8'h81, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h01, 1,  0, 8'h81, 8'h01, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 0,  1, 8'h81, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h01, 0,  1, 8'h81, 8'h00, 1, 0, 1);
    addVec(0, 0, 0, 8'h00, 0,  1, 8'h81, 8'h00, 0, 0, 1);
    // config write while firing is rejected, mask stays 0x01
    addVec(1, 3, 0, 8'h00, 0,  1, 8'h81, 8'h00, 0, 1, 1);
    addVec(0, 0, 0, 8'h00, 0,  1, 8'h81, 8'h00, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 1,  0, 8'h80, 8'h01, 0, 0, 1);
    addVec(0, 0, 0, 8'h00, 0,  0, 8'h80, 8'h00, 0, 0, 1);
    // ack outside FIRE ignored
    addVec(0, 0, 0, 8'h00, 1,  0, 8'h80, 8'h00, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].vb, vecs[i].ex, vecs[i].tok, vecs[i].ack);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_fire", i), fire, vecs[i].expFire);
      checkOutput($sformatf("vec%0d_tok_q", i), tok_q, vecs[i].expTokQ);
      checkOutput($sformatf("vec%0d_consumed", i), consumed_mask, vecs[i].expCons);
      checkOutput($sformatf("vec%0d_ovf", i), tok_ovf, vecs[i].expOvf);
      checkOutput($sformatf("vec%0d_rej", i), cfg_rej, vecs[i].expRej);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].expBusy);
    end

    // Asynchronous reset in the middle of a firing
    applyStimulus(0, 0, 0, 8'h01, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (fire === 1'b1) seen = 1;
    end
    checkOutput("async_reset_reach_fire", seen, 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_fire", fire, 0);
    checkOutput("async_reset_tok_q", tok_q, 0);
    checkOutput("async_reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("after_reset_busy", busy, 0);
    checkOutput("after_reset_fire", fire, 0);

`ifdef VALID_FIRE_TIMEOUT_EN
    // Watchdog: error after TimeoutLimit cycles in FIRE, sticky through ack
    applyStimulus(1, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h01, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (fire === 1'b1) seen = 1;
    end
    checkOutput("timeout_reach_fire", seen, 1);
    for (int k = 1; k < TimeoutLimit; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("timeout_early_%0d", k), timeout_err, 0);
    end
    @(posedge clk); #1;
    checkOutput("timeout_set", timeout_err, 1);
    applyStimulus(0, 0, 0, 8'h00, 1);
    @(posedge clk); #1;
    checkOutput("timeout_after_ack_fire", fire, 0);
    checkOutput("timeout_sticky", timeout_err, 1);
    applyStimulus(1, 1, 0, 8'h00, 0);
    @(posedge clk); #1;
    checkOutput("timeout_cleared_by_cfg", timeout_err, 0);
`endif

    // Randomized traffic against the behavioural model
    doReset();
    for (int n = 0; n < 1500; n++) begin
      rWe  = ($urandom_range(0, 9) == 0);
      rVb  = $urandom_range(0, 7);
      rEx  = ($urandom_range(0, 3) == 0);
      rTok = ($urandom & $urandom & $urandom) & 255;
      rAck = ($urandom_range(0, 2) == 0);
      applyStimulus(rWe, rVb[2:0], rEx, rTok[7:0], rAck);
      modelStep(rWe, rVb, rEx, rTok, rAck, eCons, eOvf, eRej);
`ifdef VALID_FIRE_TIMEOUT_EN
      expErr = mErr;
`else
      expErr = 0;
`endif
      @(posedge clk); #1;
      checkOutput("rand_fire", fire, mFiring);
      checkOutput("rand_tok_q", tok_q, mTok);
      checkOutput("rand_consumed", consumed_mask, eCons);
      checkOutput("rand_ovf", tok_ovf, eOvf);
      checkOutput("rand_rej", cfg_rej, eRej);
      checkOutput("rand_busy", busy, maskOf(mVb, mEx) != 0);
      checkOutput("rand_timeout", timeout_err, expErr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
